chacha_core_iter: RTL and testbench
===================================

# chacha_core_iter

Iterative, parametrised ChaCha keystream core. It takes a 256-bit key, a 96-bit nonce and a 32-bit initial block counter, then produces one or more consecutive 512-bit keystream blocks, auto-incrementing the counter. Round count and quarter-rounds per cycle are parameters, trading area against latency. It sits between the key/nonce management logic and the memory-encryption XOR datapath, with valid/ready handshakes on both sides.

## Interface
- ROUNDS, 20: total rounds; legal values 8, 12, 20 (must be even).
- QR_PER_CYCLE, 1: quarter-rounds evaluated per clock; legal values 1, 2, 4.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  job request.
- in_ready  output  1  high only in IDLE.
- key  input  256  key words k0..k7; word k at key[255-32k -: 32].
- nonce  input  96  nonce words n0..n2; word n at nonce[95-32n -: 32].
- counter  input  32  block counter for the first block.
- num_blocks  input  16  blocks to generate; 0 is treated as 1.
- abort  input  1  synchronous job cancel.
- out_valid  output  1  keystream block available.
- out_ready  input  1  consumer accepts the block.
- keystream  output  512  word i at [511-32i -: 32].
- out_counter  output  32  counter value used for the current block.
- out_last  output  1  current block is the final block of the job.
- out_ctr_wrap  output  1  counter wrapped from 0xFFFFFFFF to 0 for this block.

## Operation
- Initial state: words 0..3 are 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 4..11 are k0..k7. Word 12 is the counter. Words 13..15 are n0..n2.
- Words are taken as given. Byte order is the upstream's responsibility.
- Quarter-round order within one double round:
  - column QRs on (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15);
  - then diagonal QRs on (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
- Each cycle executes the next QR_PER_CYCLE QRs in that order. All QRs in one cycle belong to the same column or the same diagonal group.
- FSM states: IDLE, ROUND, OUT.
  - IDLE: when in_valid is high, load the working and original state and the remaining-block count, then go to ROUND with step=0.
  - ROUND: each edge advances step. On the last step, keystream is registered as working plus original, word-wise mod 2^32, and the FSM goes to OUT.
  - OUT: hold out_valid and all output fields stable until out_ready is high. On that handshake:
    - if blocks remain, increment word 12 mod 2^32, reload working from original and go to ROUND;
    - otherwise go to IDLE.
- out_ctr_wrap is set for the block whose counter is 0 after an increment wrap. Generation continues after a wrap.
- abort (any state): next edge goes to IDLE, clears out_valid, and discards the pending block.
  - abort has priority over the in/out handshakes in the same cycle.
  - In IDLE, abort suppresses the acceptance of in_valid.
- Reset values: FSM is IDLE. in_ready is 1 after reset release. out_valid, out_last and out_ctr_wrap are 0. keystream and out_counter are 0. All internal registers are cleared.
- Reset asserted mid-job drops the job immediately. No output is produced after reset release until a new request is accepted.

## Timing
- R_CYC = 4*ROUNDS/QR_PER_CYCLE: 80, 40 or 20 cycles for ChaCha20.
- Accept edge is at T. out_valid rises after the edge at T+R_CYC.
- For back-to-back blocks with out_ready tied high, the block period is R_CYC+1 cycles.
- in_ready is low from the accept edge until the edge at which the last block handshakes or abort is taken.
- in_ready is combinational from the FSM state only, never from in_valid.
- Inputs are sampled only at the accept edge. Later changes to key, nonce or counter have no effect.

## Structure
- Shared package chacha_pkg holds:
  - the four sigma constants;
  - the QR index tables for the column and diagonal groups;
  - FSM state encoding;
  - the R_CYC function;
  - a parameter legality check, which is an elaboration error on illegal ROUNDS or QR_PER_CYCLE.
- Sub-module: chacha_quarterround, the combinational ARX (add-rotate-xor) quarter-round with rotations 16, 12, 8, 7, instantiated QR_PER_CYCLE times.
- Lane operands are selected by muxing on step mod (8/QR_PER_CYCLE).

## Test plan
- Zero test (all-zero key and nonce, counter 0, ROUNDS=20, each QR_PER_CYCLE value):
  - keystream word0 is 0xade0b876 and word1 is 0x903df1a0;
  - out_valid rises exactly R_CYC cycles after accept.
- Known-answer test:
  - stimulus: key words 0x03020100, 0x07060504, and so on through 0x1f1e1d1c; nonce 0x09000000, 0x4a000000, 0x00000000; counter 1;
  - required response: word0 is 0xe4e7f110 and word15 is 0x4e3c50a2.
- Multi-block with wrap:
  - stimulus: counter 0xFFFFFFFE, num_blocks 3;
  - required response: out_counter sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; out_ctr_wrap only on the third block; out_last only on the third block.
- Backpressure:
  - stimulus: out_ready low for 10 cycles in OUT;
  - required response: outputs stay stable, the next block does not start, and in_ready stays 0.
- Abort:
  - stimulus: abort during ROUND, and abort in OUT in the same cycle as out_ready;
  - required response: IDLE next cycle, no handshake counted, and a subsequent job still matches the zero-test output.
- Reset:
  - stimulus: rst asserted mid-ROUND;
  - required response: outputs go to zero immediately, and in_ready is 1 after release.
- Also run ROUNDS=8 and ROUNDS=12 against a reference model.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared constants, quarter-round index tables, FSM encoding and parameter
// helpers for the iterative ChaCha keystream core.
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  // Eight QRs of one double round, four word indices each, QR 0 in the MSBs.
  // QRs 0..3 are the column group, 4..7 the diagonal group.
  localparam logic [127:0] QR_TABLE = {
    4'd0, 4'd4, 4'd8,  4'd12,  4'd1, 4'd5, 4'd9,  4'd13,
    4'd2, 4'd6, 4'd10, 4'd14,  4'd3, 4'd7, 4'd11, 4'd15,
    4'd0, 4'd5, 4'd10, 4'd15,  4'd1, 4'd6, 4'd11, 4'd12,
    4'd2, 4'd7, 4'd8,  4'd13,  4'd3, 4'd4, 4'd9,  4'd14
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_OUT   = 2'd2
  } chacha_state_e;

  function automatic int r_cyc(input int rounds, input int qpc);
    return (4 * rounds) / qpc;
  endfunction

  function automatic bit params_legal(input int rounds, input int qpc);
    return ((rounds == 8) || (rounds == 12) || (rounds == 20)) &&
           ((qpc == 1) || (qpc == 2) || (qpc == 4));
  endfunction

  function automatic logic [3:0] qr_word(input int qr, input int pos);
    return QR_TABLE[127 - 4 * (qr * 4 + pos) -: 4];
  endfunction

endpackage

// File: rtl/chacha_core_iter_quarterround.sv
// Combinational ChaCha quarter-round: add-rotate-xor with rotations 16, 12, 8, 7.
module chacha_quarterround (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  logic [31:0] a1, b1, c1, d1;

  assign a1    = a + b;
  assign d1    = rotl(d ^ a1, 16);
  assign c1    = c + d1;
  assign b1    = rotl(b ^ c1, 12);
  assign a_new = a1 + b1;
  assign d_new = rotl(d1 ^ a_new, 8);
  assign c_new = c1 + d_new;
  assign b_new = rotl(b1 ^ c_new, 7);

endmodule

// File: rtl/chacha_core_iter.sv
// Iterative ChaCha keystream core: QR_PER_CYCLE quarter-rounds per clock,
// multi-block jobs with automatic block-counter increment.
module chacha_core_iter
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  input  logic [15:0]  num_blocks,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic [31:0]  out_counter,
  output logic         out_last,
  output logic         out_ctr_wrap,
  output logic [1:0]   state_dbg
);

  localparam int R_CYC     = r_cyc(ROUNDS, QR_PER_CYCLE);
  localparam int STEP_W    = $clog2(R_CYC);
  localparam int SUB_STEPS = 8 / QR_PER_CYCLE;
  localparam int SUB_W     = $clog2(SUB_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(R_CYC - 1);

  if (!params_legal(ROUNDS, QR_PER_CYCLE)) begin : g_illegal_params
    $error("chacha_core_iter: illegal ROUNDS=%0d / QR_PER_CYCLE=%0d", ROUNDS, QR_PER_CYCLE);
  end

  chacha_state_e       state_q, state_d;
  logic [STEP_W-1:0]   step_q;
  logic [15:0]         blocks_left_q;
  logic                ctr_wrap_q;
  logic [31:0]         work_q    [16];
  logic [31:0]         orig_q    [16];
  logic [31:0]         work_next [16];
  logic [31:0]         init_w    [16];
  logic [511:0]        ks_sum;
  logic [511:0]        keystream_q;
  logic [31:0]         out_counter_q;
  logic                out_last_q;
  logic                out_ctr_wrap_q;
  logic [SUB_W-1:0]    sub;
  logic                accept, out_fire, last_step, more_blocks;
  logic [31:0]         ctr_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; abort wins over either transfer in the same cycle.
  assign accept      = (state_q == ST_IDLE) && in_valid && !abort;
  assign out_fire    = (state_q == ST_OUT) && out_ready && !abort;
  assign last_step   = (step_q == LAST_STEP);
  assign more_blocks = (blocks_left_q > 16'd1);
  assign ctr_next    = orig_q[12] + 32'd1;
  assign sub         = step_q[SUB_W-1:0];

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_OUT);
  assign keystream    = keystream_q;
  assign out_counter  = out_counter_q;
  assign out_last     = out_last_q;
  assign out_ctr_wrap = out_ctr_wrap_q;
  assign state_dbg    = state_q;

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (in_valid) state_d = ST_ROUND;
        ST_ROUND: if (last_step) state_d = ST_OUT;
        ST_OUT:   if (out_ready) state_d = more_blocks ? ST_ROUND : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    init_w[0]  = SIGMA0;
    init_w[1]  = SIGMA1;
    init_w[2]  = SIGMA2;
    init_w[3]  = SIGMA3;
    for (int k = 0; k < 8; k++) init_w[4 + k] = key[255 - 32 * k -: 32];
    init_w[12] = counter;
    for (int n = 0; n < 3; n++) init_w[13 + n] = nonce[95 - 32 * n -: 32];
  end

  // Lanes of one cycle are consecutive QRs of the same column/diagonal group.
  logic [3:0]  ia [QR_PER_CYCLE];
  logic [3:0]  ib [QR_PER_CYCLE];
  logic [3:0]  ic [QR_PER_CYCLE];
  logic [3:0]  id [QR_PER_CYCLE];
  logic [31:0] na [QR_PER_CYCLE];
  logic [31:0] nb [QR_PER_CYCLE];
  logic [31:0] nc [QR_PER_CYCLE];
  logic [31:0] nd [QR_PER_CYCLE];

  for (genvar j = 0; j < QR_PER_CYCLE; j++) begin : g_lane
    logic [2:0] qr_sel;
    assign qr_sel = 3'((32'(sub) * QR_PER_CYCLE) + j);
    assign ia[j]  = qr_word(int'(qr_sel), 0);
    assign ib[j]  = qr_word(int'(qr_sel), 1);
    assign ic[j]  = qr_word(int'(qr_sel), 2);
    assign id[j]  = qr_word(int'(qr_sel), 3);

    chacha_quarterround u_qr (
      .a     (work_q[ia[j]]),
      .b     (work_q[ib[j]]),
      .c     (work_q[ic[j]]),
      .d     (work_q[id[j]]),
      .a_new (na[j]),
      .b_new (nb[j]),
      .c_new (nc[j]),
      .d_new (nd[j])
    );
  end

  always_comb begin
    for (int w = 0; w < 16; w++) work_next[w] = work_q[w];
    for (int j = 0; j < QR_PER_CYCLE; j++) begin
      work_next[ia[j]] = na[j];
      work_next[ib[j]] = nb[j];
      work_next[ic[j]] = nc[j];
      work_next[id[j]] = nd[j];
    end
  end

  always_comb begin
    ks_sum = '0;
    for (int w = 0; w < 16; w++) ks_sum[511 - 32 * w -: 32] = work_next[w] + orig_q[w];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      step_q         <= '0;
      blocks_left_q  <= '0;
      ctr_wrap_q     <= 1'b0;
      keystream_q    <= '0;
      out_counter_q  <= '0;
      out_last_q     <= 1'b0;
      out_ctr_wrap_q <= 1'b0;
      for (int w = 0; w < 16; w++) begin
        work_q[w] <= '0;
        orig_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        step_q        <= '0;
        blocks_left_q <= (num_blocks == 16'd0) ? 16'd1 : num_blocks;
        ctr_wrap_q    <= 1'b0;
        for (int w = 0; w < 16; w++) begin
          work_q[w] <= init_w[w];
          orig_q[w] <= init_w[w];
        end
      end else if ((state_q == ST_ROUND) && !abort) begin
        step_q <= last_step ? '0 : step_q + 1'b1;
        for (int w = 0; w < 16; w++) work_q[w] <= work_next[w];
        if (last_step) begin
          keystream_q    <= ks_sum;
          out_counter_q  <= orig_q[12];
          out_last_q     <= !more_blocks;
          out_ctr_wrap_q <= ctr_wrap_q;
        end
      end else if (out_fire && more_blocks) begin
        step_q        <= '0;
        blocks_left_q <= blocks_left_q - 16'd1;
        ctr_wrap_q    <= (ctr_next == 32'd0);
        orig_q[12]    <= ctr_next;
        for (int w = 0; w < 16; w++) work_q[w] <= (w == 12) ? ctr_next : orig_q[w];
      end
    end
  end

endmodule

// File: tb/tb_chacha_core_iter.sv
// Self-checking bench: five core configurations share one stimulus stream and
// are compared against a whole-block ChaCha reference model.
module tb_chacha_core_iter;

  localparam int NDUT = 5;
  localparam int CFG_ROUNDS [NDUT] = '{20, 20, 20, 8, 12};
  localparam int CFG_QPC    [NDUT] = '{1, 2, 4, 4, 2};
  localparam logic [NDUT-1:0] ALL = '1;

  logic         clk, rst, in_valid, abort, out_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic [15:0]  num_blocks;

  logic [NDUT-1:0] in_ready_v, out_valid_v, out_last_v, out_wrap_v;
  logic [511:0]    ks_a [NDUT];
  logic [31:0]     oc_a [NDUT];
  logic [1:0]      st_a [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    chacha_core_iter #(.ROUNDS(CFG_ROUNDS[g]), .QR_PER_CYCLE(CFG_QPC[g])) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready_v[g]),
      .key          (key),
      .nonce        (nonce),
      .counter      (counter),
      .num_blocks   (num_blocks),
      .abort        (abort),
      .out_valid    (out_valid_v[g]),
      .out_ready    (out_ready),
      .keystream    (ks_a[g]),
      .out_counter  (oc_a[g]),
      .out_last     (out_last_v[g]),
      .out_ctr_wrap (out_wrap_v[g]),
      .state_dbg    (st_a[g])
    );
  end

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [545:0] exp_q [$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] qrp(input logic [511:0] st, input int ai, input int bi,
                                       input int ci, input int di);
    logic [31:0] a, b, c, d;
    logic [511:0] r;
    a = st[511 - 32 * ai -: 32];
    b = st[511 - 32 * bi -: 32];
    c = st[511 - 32 * ci -: 32];
    d = st[511 - 32 * di -: 32];
    a = a + b; d = rl(d ^ a, 16);
    c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);
    c = c + d; b = rl(b ^ c, 7);
    r = st;
    r[511 - 32 * ai -: 32] = a;
    r[511 - 32 * bi -: 32] = b;
    r[511 - 32 * ci -: 32] = c;
    r[511 - 32 * di -: 32] = d;
    return r;
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c, input int rounds);
    logic [511:0] s, x, r;
    s = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574, k, c, n};
    x = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int i = 0; i < 4; i++) x = qrp(x, i, i + 4, i + 8, i + 12);
      for (int i = 0; i < 4; i++)
        x = qrp(x, i, 4 + (i + 1) % 4, 8 + (i + 2) % 4, 12 + (i + 3) % 4);
    end
    for (int w = 0; w < 16; w++) r[32 * w +: 32] = x[32 * w +: 32] + s[32 * w +: 32];
    return r;
  endfunction

  function automatic int exp_rcyc(input int g);
    return 4 * CFG_ROUNDS[g] / CFG_QPC[g];
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [95:0] rand_nonce();
    logic [95:0] r;
    for (int i = 0; i < 3; i++) r[32 * i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Returns at the falling edge right after the accept edge.
  task automatic start_job(input logic [255:0] k, input logic [95:0] n,
                           input logic [31:0] c, input logic [15:0] nb);
    @(negedge clk);
    check("idle_ready", in_ready_v, ALL);
    key = k; nonce = n; counter = c; num_blocks = nb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", in_ready_v, '0);
  endtask

  task automatic wait_all_valid(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while ((out_valid_v != ALL) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
    end
    if (out_valid_v != ALL) check(tag, out_valid_v, ALL);
  endtask

  task automatic handshake_single();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_ready", in_ready_v, ALL);
    check("post_hs_valid", out_valid_v, '0);
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (out_valid_v != '0) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic check_all_blocks(input string tag, input logic [255:0] k, input logic [95:0] n,
                                  input logic [31:0] c);
    for (int g = 0; g < NDUT; g++) begin
      check({tag, "_ks"}, ks_a[g], ref_block(k, n, c, CFG_ROUNDS[g]));
      check({tag, "_ctr"}, oc_a[g], c);
    end
    check({tag, "_last"}, out_last_v, ALL);
    check({tag, "_wrap"}, out_wrap_v, '0);
  endtask

  // ---------------- main sequence ----------------
  logic [255:0] k, kat_key;
  logic [95:0]  n;
  logic [31:0]  c;
  logic [545:0] exp_item;
  logic [511:0] snap_ks;
  logic [32:0]  snap_misc;
  int           lat [NDUT];
  int           t_blk [3];
  int           nblk, cyc0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    key = '0; nonce = '0; counter = '0; num_blocks = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid_v, '0);
    check("rst_last", out_last_v, '0);
    check("rst_wrap", out_wrap_v, '0);
    check("rst_ks", ks_a[0], '0);
    check("rst_ctr", oc_a[0], '0);
    check("rst_state", st_a[0], 2'(chacha_pkg::ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", in_ready_v, ALL);

    // zero test with exact latency for every configuration
    start_job('0, '0, 32'd0, 16'd1);
    for (int g = 0; g < NDUT; g++) lat[g] = -1;
    for (int cyc = 1; cyc <= 100 && (out_valid_v != ALL); cyc++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) if (out_valid_v[g] && lat[g] < 0) lat[g] = cyc;
    end
    for (int g = 0; g < NDUT; g++) check("zero_latency", lat[g], exp_rcyc(g));
    for (int g = 0; g < 3; g++) begin
      check("zero_w0", ks_a[g][511 -: 32], 32'hade0b876);
      check("zero_w1", ks_a[g][479 -: 32], 32'h903df1a0);
    end
    check_all_blocks("zero", '0, '0, 32'd0);
    handshake_single();

    // known-answer test
    for (int i = 0; i < 8; i++) kat_key[255 - 32 * i -: 32] = 32'h03020100 + 32'h04040404 * i;
    n = {32'h09000000, 32'h4a000000, 32'h00000000};
    start_job(kat_key, n, 32'd1, 16'd1);
    wait_all_valid("kat_timeout", 100);
    for (int g = 0; g < 3; g++) begin
      check("kat_w0", ks_a[g][511 -: 32], 32'he4e7f110);
      check("kat_w15", ks_a[g][31:0], 32'h4e3c50a2);
    end
    check_all_blocks("kat", kat_key, n, 32'd1);
    handshake_single();

    // multi-block job across the counter wrap, consumer always ready
    k = rand_key(); n = rand_nonce();
    exp_q.delete();
    for (int b = 0; b < 3; b++) begin
      c = 32'hFFFF_FFFE + 32'(b);
      exp_q.push_back({(b == 2), (b == 2), c, ref_block(k, n, c, 20)});
    end
    for (int i = 0; i < 3; i++) t_blk[i] = 0;
    nblk = 0;
    out_ready = 1'b1;
    start_job(k, n, 32'hFFFF_FFFE, 16'd3);
    for (int cyc = 1; cyc <= 400 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (out_valid_v[0]) begin
        exp_item = exp_q.pop_front();
        check("wrap_ks", ks_a[0], exp_item[511:0]);
        check("wrap_ctr", oc_a[0], exp_item[543:512]);
        check("wrap_flag", out_wrap_v[0], exp_item[544]);
        check("wrap_last", out_last_v[0], exp_item[545]);
        check("wrap_busy", in_ready_v[0], 1'b0);
        if (nblk < 3) t_blk[nblk] = cyc;
        nblk++;
      end
    end
    check("wrap_count", exp_q.size(), 0);
    check("wrap_first_lat", t_blk[0], 80);
    check("wrap_period1", t_blk[1] - t_blk[0], 81);
    check("wrap_period2", t_blk[2] - t_blk[1], 81);
    @(negedge clk);
    out_ready = 1'b0;
    check("wrap_done_ready", in_ready_v, ALL);

    // backpressure: hold block 0 for 10 cycles, then release
    k = rand_key(); n = rand_nonce(); c = $urandom();
    start_job(k, n, c, 16'd2);
    cyc0 = 0;
    while (!out_valid_v[0] && cyc0 < 100) begin
      @(negedge clk);
      cyc0++;
    end
    check("bp_latency", cyc0, 80);
    check("bp_ks0", ks_a[0], ref_block(k, n, c, 20));
    check("bp_last0", out_last_v[0], 1'b0);
    snap_ks   = ks_a[0];
    snap_misc = {out_valid_v[0], oc_a[0]};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_ks", ks_a[0], snap_ks);
      check("bp_hold_misc", {out_valid_v[0], oc_a[0]}, snap_misc);
      check("bp_hold_busy", in_ready_v, '0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    cyc0 = 0;
    while (!out_valid_v[0] && cyc0 < 100) begin
      @(negedge clk);
      cyc0++;
    end
    check("bp_period", cyc0, 80);
    check("bp_ks1", ks_a[0], ref_block(k, n, c + 32'd1, 20));
    check("bp_ctr1", oc_a[0], c + 32'd1);
    check("bp_last1", out_last_v[0], 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_done_ready", in_ready_v, ALL);

    // abort during ROUND
    start_job(rand_key(), rand_nonce(), $urandom(), 16'd2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_round_ready", in_ready_v, ALL);
    check("abort_round_valid", out_valid_v, '0);
    expect_quiet("abort_round_quiet", 90);

    // abort in OUT together with out_ready
    start_job(rand_key(), rand_nonce(), $urandom(), 16'd2);
    wait_all_valid("abort_out_timeout", 100);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    check("abort_out_ready", in_ready_v, ALL);
    check("abort_out_valid", out_valid_v, '0);
    expect_quiet("abort_out_quiet", 90);

    // abort suppresses acceptance in IDLE
    @(negedge clk);
    key = rand_key(); num_blocks = 16'd1; in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_ready", in_ready_v, ALL);
    expect_quiet("abort_idle_quiet", 90);

    // subsequent job still produces the zero-test block
    start_job('0, '0, 32'd0, 16'd1);
    wait_all_valid("post_abort_timeout", 100);
    check("post_abort_w0", ks_a[0][511 -: 32], 32'hade0b876);
    check_all_blocks("post_abort", '0, '0, 32'd0);
    handshake_single();

    // asynchronous reset in the middle of ROUND
    start_job(rand_key(), rand_nonce(), $urandom(), 16'd2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check("midrst_ks", ks_a[g], '0);
      check("midrst_ctr", oc_a[g], '0);
    end
    check("midrst_valid", out_valid_v, '0);
    check("midrst_last", out_last_v, '0);
    check("midrst_ready", in_ready_v, ALL);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", in_ready_v, ALL);
    expect_quiet("midrst_quiet", 90);

    // randomized single-block jobs; inputs scrambled after the accept edge
    for (int j = 0; j < 4; j++) begin
      k = rand_key(); n = rand_nonce(); c = $urandom();
      start_job(k, n, c, 16'($urandom_range(0, 1)));
      key = rand_key(); nonce = rand_nonce(); counter = $urandom();
      wait_all_valid("rand_timeout", 100);
      check_all_blocks("rand", k, n, c);
      handshake_single();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
